// File: rtl/jk_test_pkg.sv
// Shared state and J/K phase encodings for the JK flip-flop checker.
package jk_test_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        RUN,
        FINAL,
        DONE
    } state_t;

    localparam logic [1:0] PH_HOLD = 2'b00;
    localparam logic [1:0] PH_RST  = 2'b01;
    localparam logic [1:0] PH_SET  = 2'b10;
    localparam logic [1:0] PH_TGL  = 2'b11;

    function automatic int hold_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jk_ref_model.sv
// Combinational next-state function of an ideal JK flip-flop.
module jk_ref_model
    import jk_test_pkg::*;
(
    input  logic q,
    input  logic j,
    input  logic k,
    output logic next_q
);

    always_comb begin
        next_q = q;
        unique case ({j, k})
            PH_HOLD: next_q = q;
            PH_RST:  next_q = 1'b0;
            PH_SET:  next_q = 1'b1;
            PH_TGL:  next_q = ~q;
        endcase
    end

endmodule

// File: rtl/jk_flipflop_checker.sv
// Drives J/K through all four commands and scores the flip-flop
// against a reference model on every clock.
module jk_flipflop_checker
    import jk_test_pkg::*;
#(
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             dut_q,
    input  logic             dut_qnot,
    output logic             j,
    output logic             k,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] error_count
);

    localparam int HW = hold_w(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    state_t           state, state_n;
    logic             j_n, k_n;
    logic             busy_n, done_n, pass_n;
    logic [CNT_W-1:0] err_n, err_inc;
    logic             exp_q, exp_q_n, model_q;
    logic [1:0]       phase, phase_n;
    logic [HW-1:0]    hold_cnt, hold_n;
    logic             miss;

    jk_ref_model u_ref (
        .q      (exp_q),
        .j      (j),
        .k      (k),
        .next_q (model_q)
    );

    // Case inequality so that X/Z from the flip-flop scores as a miss
    assign miss    = (dut_q !== exp_q) || (dut_qnot !== ~exp_q);
    assign err_inc = (error_count == '1) ? error_count
                                         : error_count + CNT_W'(1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            j           <= 1'b0;
            k           <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            error_count <= '0;
            exp_q       <= 1'b0;
            phase       <= 2'd0;
            hold_cnt    <= '0;
        end else begin
            state       <= state_n;
            j           <= j_n;
            k           <= k_n;
            busy        <= busy_n;
            done        <= done_n;
            pass        <= pass_n;
            error_count <= err_n;
            exp_q       <= exp_q_n;
            phase       <= phase_n;
            hold_cnt    <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        j_n     = j;
        k_n     = k;
        busy_n  = busy;
        done_n  = done;
        pass_n  = pass;
        err_n   = error_count;
        exp_q_n = exp_q;
        phase_n = phase;
        hold_n  = hold_cnt;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n    = INIT;
                    {j_n, k_n} = PH_RST;
                    busy_n     = 1'b1;
                    done_n     = 1'b0;
                    pass_n     = 1'b0;
                    err_n      = '0;
                end
            end
            INIT: begin
                exp_q_n    = 1'b0;
                state_n    = RUN;
                phase_n    = 2'd0;
                hold_n     = '0;
                {j_n, k_n} = PH_HOLD;
            end
            RUN: begin
                if (miss) err_n = err_inc;
                exp_q_n = model_q;
                if (hold_cnt == HOLD_LAST) begin
                    hold_n = '0;
                    if (phase == PH_TGL) begin
                        state_n    = FINAL;
                        {j_n, k_n} = PH_HOLD;
                    end else begin
                        // Phase index doubles as its J/K encoding
                        phase_n    = phase + 2'd1;
                        {j_n, k_n} = phase + 2'd1;
                    end
                end else begin
                    hold_n = hold_cnt + 1'b1;
                end
            end
            FINAL: begin
                if (miss) err_n = err_inc;
                state_n    = DONE;
                busy_n     = 1'b0;
                done_n     = 1'b1;
                pass_n     = (err_n == '0);
                {j_n, k_n} = PH_HOLD;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_jk_flipflop_checker.sv
// Directed bench: three checker instances beside behavioural JK flops
// with selectable faults.
module tb_jk_flipflop_checker;

    logic       clock;
    logic       reset;
    logic       start;
    int         fault;
    logic [2:0] jv, kv, ff, qv, qnv;
    logic [2:0] busyv, donev, passv;
    logic [7:0] err0, err1;
    logic [1:0] err2;

    int checks = 0;
    int errors = 0;

    jk_flipflop_checker #(.HOLD_CYCLES(2), .CNT_W(8)) u_main (
        .clock(clock), .reset(reset), .start(start),
        .dut_q(qv[0]), .dut_qnot(qnv[0]),
        .j(jv[0]), .k(kv[0]),
        .busy(busyv[0]), .done(donev[0]), .pass(passv[0]),
        .error_count(err0)
    );

    jk_flipflop_checker #(.HOLD_CYCLES(1), .CNT_W(8)) u_h1 (
        .clock(clock), .reset(reset), .start(start),
        .dut_q(qv[1]), .dut_qnot(qnv[1]),
        .j(jv[1]), .k(kv[1]),
        .busy(busyv[1]), .done(donev[1]), .pass(passv[1]),
        .error_count(err1)
    );

    jk_flipflop_checker #(.HOLD_CYCLES(2), .CNT_W(2)) u_sat (
        .clock(clock), .reset(reset), .start(start),
        .dut_q(qv[2]), .dut_qnot(qnv[2]),
        .j(jv[2]), .k(kv[2]),
        .busy(busyv[2]), .done(donev[2]), .pass(passv[2]),
        .error_count(err2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            case ({jv[i], kv[i]})
                2'b01: ff[i] <= 1'b0;
                2'b10: ff[i] <= 1'b1;
                2'b11: ff[i] <= ~ff[i];
                default: ;
            endcase
        end
    end

    // fault 1: Q stuck at 0; fault 2: Qnot tied to Q
    assign qv  = (fault == 1) ? 3'b000 : ff;
    assign qnv = (fault == 2) ? qv : ~qv;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic run_full();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
    endtask

    logic [1:0] jk_exp [11];
    int pulses;

    initial begin
        jk_exp = '{2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10,
                   2'b10, 2'b11, 2'b11, 2'b00, 2'b00};
        reset = 1'b1;
        start = 1'b0;
        fault = 0;
        tick();
        tick();
        chk("rst_busy", busyv, 3'b000);
        chk("rst_done", donev, 3'b000);
        chk("rst_pass", passv, 3'b000);
        chk("rst_jk", {jv, kv}, 6'd0);
        chk("rst_err", err0, 0);
        reset = 1'b0;
        tick();
        chk("idle_busy", busyv[0], 0);

        // correct flop, full walk
        start = 1'b1;
        for (int e = 0; e <= 10; e++) begin
            if (e > 0) tick();
            else begin
                tick();
                start = 1'b0;
            end
            chk($sformatf("jk_e%0d", e), {jv[0], kv[0]}, jk_exp[e]);
            chk($sformatf("h1_done_e%0d", e), donev[1], (e >= 6));
            if (e == 9) chk("busy_e9", {busyv[0], donev[0]}, 2'b10);
        end
        chk("ok_done", {donev[0], busyv[0]}, 2'b10);
        chk("ok_pass", passv, 3'b111);
        chk("ok_err", err0, 0);
        chk("h1_err", err1, 0);

        fault = 1;
        run_full();
        chk("stk_err", err0, 3);
        chk("stk_pass", passv[0], 0);
        chk("stk_h1_err", err1, 1);
        chk("stk_sat_err", err2, 3);

        fault = 2;
        run_full();
        chk("tie_err", err0, 9);
        chk("tie_h1_err", err1, 5);
        chk("tie_sat_err", err2, 3);
        chk("tie_pass", passv, 3'b000);
        chk("tie_done", donev, 3'b111);

        // reset mid-run at E5
        fault = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("mid_busy", busyv[0], 1);
        reset = 1'b1;
        tick();
        chk("mrst_jk", {jv[0], kv[0]}, 2'b00);
        chk("mrst_flags", {busyv[0], donev[0]}, 2'b00);
        chk("mrst_err", err0, 0);
        reset = 1'b0;
        tick();
        chk("mrst_idle", busyv[0], 0);
        run_full();
        chk("rerun_done", donev[0], 1);
        chk("rerun_pass", passv[0], 1);
        chk("rerun_err", err0, 0);

        // start held high: restarts every time DONE is entered
        pulses = 0;
        start = 1'b1;
        for (int e = 0; e < 33; e++) begin
            tick();
            chk($sformatf("hold_done_e%0d", e), donev[0], (e % 11) == 10);
            chk($sformatf("hold_busy_e%0d", e), busyv[0], (e % 11) != 10);
            chk($sformatf("hold_h1_e%0d", e), donev[1], (e % 7) == 6);
            if (donev[0]) begin
                pulses++;
                chk("hold_pass", passv[0], 1);
            end
        end
        start = 1'b0;
        chk("hold_pulses", pulses, 3);

        // reset wins over start
        reset = 1'b1;
        start = 1'b1;
        tick();
        chk("rs_busy", busyv, 3'b000);
        chk("rs_done", donev, 3'b000);
        reset = 1'b0;
        start = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
